dmem_arbiter: RTL and testbench

//   Shares the single data-memory port between the mips core (memory stage) and
//   a DMA/debug loader master. Arbitration is per beat with round-robin fairness.
//   A DMA burst holds ownership, bounded by MAX_BURST when the CPU is waiting.

---
 rtl/dmem_arbiter.sv | 65 ++++++
 tb/tb_dmem_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin per-beat arbiter sharing one data-memory port between the CPU and a DMA master.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int SCW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wd,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [SCW-1:0] stall_cnt
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic last_gnt, last_gnt_nx, gnt_cpu, gnt_dma, yield;
    logic [BW-1:0] beat_cnt, beat_cnt_nx, beat_inc;
    // beat_cnt saturates at MAX_BURST so a long unbounded burst still yields as soon as the CPU asks
    always_comb begin
        beat_inc    = state == IDLE ? BW'(1) : (beat_cnt == BMAX ? beat_cnt : beat_cnt + BW'(1));
        yield       = cpu_req && beat_inc == BMAX;
        gnt_cpu     = !reset ? 1'b0 : state == IDLE ? cpu_req & (~dma_req | last_gnt) : cpu_req & ~dma_req;
        gnt_dma     = !reset ? 1'b0 : state == IDLE ? dma_req & (~cpu_req | ~last_gnt) : dma_req;
        state_nx    = gnt_dma && !dma_last && !yield ? BURST : IDLE;
        beat_cnt_nx = state_nx == BURST ? beat_inc : '0;
        last_gnt_nx = gnt_dma ? 1'b1 : gnt_cpu ? 1'b0 : last_gnt;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            last_gnt  <= last_gnt_nx;
            beat_cnt  <= beat_cnt_nx;
            stall_cnt <= stall_cnt + SCW'(cpu_stall & ~&stall_cnt);
        end
    end
    assign cpu_stall = reset & cpu_req & ~gnt_cpu;
    assign dma_gnt   = gnt_dma;
    assign mem_we    = gnt_cpu ? cpu_we : gnt_dma & dma_we;
    assign mem_addr  = gnt_dma ? dma_addr : cpu_addr;
    assign mem_wd    = gnt_dma ? dma_wd : cpu_wd;
    assign cpu_rd    = mem_rd;
    assign dma_rd    = mem_rd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic checked against a transaction-level arbiter model.
module tb_dmem_arbiter;
    localparam int MAXB = 4;
    logic clk = 0, reset;
    logic cpu_req, cpu_we, dma_req, dma_we, dma_last;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
    logic [31:0] cpu_rd, dma_rd, mem_addr, mem_wd, mem_rd;
    logic cpu_stall, dma_gnt, mem_we;
    logic [15:0] stall_cnt;
    logic [31:0] dmem [16] = '{default: 0};
    logic [31:0] ref_mem [16] = '{default: 0};
    int n_chk = 0, n_fail = 0;
    bit m_burst, m_last, ec, ed;
    int m_beats, m_stall;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB), .SCW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rd(dma_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .stall_cnt(stall_cnt));

    always #5 clk = ~clk;
    assign mem_rd = dmem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, check against the model, then advance the model
    task automatic cyc(input logic r, input logic c, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                       input logic d, input logic dw, input logic [31:0] da, input logic [31:0] dwd, input logic dl);
        int nb;
        @(negedge clk);
        reset = r; cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wd = cwd;
        dma_req = d; dma_we = dw; dma_addr = da; dma_wd = dwd; dma_last = dl;
        #1;
        ed = r && d && (m_burst || !c || !m_last);
        ec = r && c && !ed;
        chk("dma_gnt", dma_gnt, ed);
        chk("cpu_stall", cpu_stall, r && c && !ec);
        chk("mem_we", mem_we, ec ? cw : ed && dw);
        chk("stall_cnt", stall_cnt, m_stall);
        if (ec || ed) chk("mem_addr", mem_addr, ed ? da : ca);
        if ((ec && cw) || (ed && dw)) chk("mem_wd", mem_wd, ed ? dwd : cwd);
        if (ec && !cw) chk("cpu_rd", cpu_rd, ref_mem[ca[5:2]]);
        if (ed && !dw) chk("dma_rd", dma_rd, ref_mem[da[5:2]]);
        if (!r) begin
            m_burst = 0; m_last = 1; m_beats = 0; m_stall = 0;
        end else begin
            if (c && !ec && m_stall < 65535) m_stall++;
            if (ed) begin
                nb = m_burst ? m_beats + 1 : 1;
                m_last = 1;
                m_burst = !dl && !(c && nb >= MAXB);
                m_beats = m_burst ? nb : 0;
                if (dw) ref_mem[da[5:2]] = dwd;
            end else begin
                if (ec) m_last = 0;
                if (ec && cw) ref_mem[ca[5:2]] = cwd;
                m_burst = 0; m_beats = 0;
            end
        end
    endtask

    task automatic idle_cycles(input logic r, input int n);
        for (int i = 0; i < n; i++) cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle_cycles(0, 2);
        chk("rst_stall_cnt", stall_cnt, 0);
        // CPU-only store then load of the same word
        cyc(1, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("t1_we", mem_we, 1);
        cyc(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("t1_rd", cpu_rd, 32'hDEADBEEF);
        // Both single-beat right after reset: CPU, DMA, CPU
        idle_cycles(0, 1);
        cyc(1, 1, 0, 32'h4, 0, 1, 1, 32'h8, 32'h11, 1);
        chk("t2_c0_cpu", cpu_stall, 0);
        cyc(1, 1, 0, 32'h4, 0, 1, 1, 32'h8, 32'h22, 1);
        chk("t2_c1_dma", {dma_gnt, cpu_stall}, 2'b11);
        cyc(1, 1, 0, 32'h4, 0, 1, 1, 32'h8, 32'h33, 1);
        chk("t2_c2_cpu", cpu_stall, 0);
        idle_cycles(1, 1);
        chk("t2_stall", stall_cnt, 1);
        // 8-beat burst with CPU waiting: 4 DMA, 1 CPU, 4 DMA
        cyc(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        begin
            int beats = 0;
            for (int i = 0; i < 9; i++) begin
                cyc(1, 1, 0, 32'h10, 0, 1, 1, 32'h20 + 4 * beats, 32'hA0 + beats, beats == 7);
                chk("t3_cpu_slot", !cpu_stall, i == 4);
                if (dma_gnt) beats++;
            end
            chk("t3_beats", beats, 8);
        end
        cyc(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("t3_stall", stall_cnt, 9);
        // 3-beat burst ending with dma_last, then CPU straight in
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 0, 32'h20 + 4 * i, 0, i == 2);
        cyc(1, 1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
        chk("t4_cpu", cpu_stall, 0);
        // 10 contiguous beats with no CPU demand
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 1, 4 * i, 32'hB0 + i, i == 9);
            chk("t5_beat", dma_gnt, 1);
        end
        // Reset in the middle of a burst
        cyc(1, 0, 0, 0, 0, 1, 1, 32'h30, 32'h55, 0);
        cyc(1, 0, 0, 0, 0, 1, 1, 32'h34, 32'h66, 0);
        cyc(0, 1, 1, 32'h8, 32'h77, 1, 1, 32'h38, 32'h88, 0);
        chk("t6_rst_out", {mem_we, dma_gnt, cpu_stall}, 3'b000);
        cyc(1, 1, 0, 32'h8, 0, 1, 0, 32'h38, 0, 0);
        chk("t6_cpu_first", {cpu_stall, dma_gnt}, 2'b00);
        chk("t6_stall", stall_cnt, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 6, 1'($urandom),
                $urandom_range(0, 63), $urandom, $urandom_range(0, 9) < 6, 1'($urandom),
                $urandom_range(0, 63), $urandom, $urandom_range(0, 9) < 3);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
